// File: rtl/mem_sram_ctrl.sv
// Memory-stage controller: splits each 32-bit load/store into two
// 16-bit SRAM accesses with a programmable wait, stalling via ready.
module mem_sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_e;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        op_wr_q, op_wr_d;
  logic [16:0] word_q, word_d;
  logic [15:0] wdata_hi_q, wdata_hi_d;
  logic [31:0] rdata_q, rdata_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] dq_q, dq_d;
  logic        oe_q, oe_d;
  logic        we_n_q, we_n_d;

  logic        req;
  logic        phase_end;
  logic [31:0] off;
  logic        unused_off;

  assign req        = rd_en | wr_en;
  assign phase_end  = (cnt_q == LAST);
  assign off        = address - BASE_ADDR;
  assign unused_off = ^{off[31:19], off[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end
      end
      S_LOW: begin
        if (phase_end) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_HIGH: begin
        if (phase_end) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs are registered so they only move on phase entry.
  always_comb begin
    ready      = 1'b0;
    op_wr_d    = op_wr_q;
    word_d     = word_q;
    wdata_hi_d = wdata_hi_q;
    rdata_d    = rdata_q;
    addr_d     = addr_q;
    dq_d       = dq_q;
    oe_d       = oe_q;
    we_n_d     = we_n_q;
    unique case (state_q)
      S_IDLE: begin
        ready = ~req;
        if (req) begin
          op_wr_d    = wr_en;
          word_d     = off[18:2];
          wdata_hi_d = write_data[31:16];
          addr_d     = {off[18:2], 1'b0};
          dq_d       = write_data[15:0];
          oe_d       = wr_en;
          we_n_d     = ~wr_en;
        end
      end
      S_LOW: begin
        if (phase_end) begin
          if (!op_wr_q) rdata_d[15:0] = sram_dq_in;
          addr_d = {word_q, 1'b1};
          dq_d   = wdata_hi_q;
        end
      end
      S_HIGH: begin
        if (phase_end) begin
          if (!op_wr_q) rdata_d[31:16] = sram_dq_in;
          oe_d   = 1'b0;
          we_n_d = 1'b1;
        end
      end
      S_DONE:  ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_wr_q    <= 1'b0;
      word_q     <= '0;
      wdata_hi_q <= '0;
      rdata_q    <= '0;
      addr_q     <= '0;
      dq_q       <= '0;
      oe_q       <= 1'b0;
      we_n_q     <= 1'b1;
    end else begin
      op_wr_q    <= op_wr_d;
      word_q     <= word_d;
      wdata_hi_q <= wdata_hi_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      dq_q       <= dq_d;
      oe_q       <= oe_d;
      we_n_q     <= we_n_d;
    end
  end

  assign read_data   = rdata_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_q;
  assign sram_dq_oe  = oe_q;
  assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Bench for mem_sram_ctrl: vector table, corner sequences and
// randomized loads/stores against a word-level memory model.
module tb_mem_sram_ctrl;

  localparam int W  = 2;
  localparam int NC = 2 * W + 2;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  always #5 clk = ~clk;

  mem_sram_ctrl #(
    .WAIT_CYCLES(W),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rd_en(rd_en),
    .wr_en(wr_en),
    .address(address),
    .write_data(write_data),
    .read_data(read_data),
    .ready(ready),
    .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe),
    .sram_we_n(sram_we_n)
  );

  bit [15:0]   mem [262144];
  logic        pl_en = 1'b0;
  logic [17:0] pl_addr = '0;
  logic [15:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (!sram_we_n) mem[sram_addr] <= sram_dq_out;
  end

  assign sram_dq_in = mem[sram_addr];

  int n_pass = 0;
  int n_total = 0;

  logic        obs_ready [16];
  logic [17:0] obs_addr  [16];
  logic [15:0] obs_dq    [16];
  logic        obs_we    [16];
  logic        obs_oe    [16];
  logic [31:0] obs_rdata;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [17:0] lo;
    logic [17:0] hi;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic preload(input logic [17:0] a, input logic [15:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  // Called 1ns after a rising edge; returns 1ns after the edge that
  // starts cycle NC (IDLE again).
  task automatic run_access(input logic r, input logic w,
                            input logic [31:0] a, input logic [31:0] d,
                            input bit hold);
    rd_en      = r;
    wr_en      = w;
    address    = a;
    write_data = d;
    for (int c = 0; c < NC; c++) begin
      @(negedge clk);
      obs_ready[c] = ready;
      obs_addr[c]  = sram_addr;
      obs_dq[c]    = sram_dq_out;
      obs_we[c]    = sram_we_n;
      obs_oe[c]    = sram_dq_oe;
      if (c == NC - 1) obs_rdata = read_data;
      @(posedge clk);
      #1;
      if (!hold) begin
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        address    = $urandom;
        write_data = $urandom;
      end
    end
  endtask

  task automatic check_trace(input string tag, input logic wop,
                             input logic [31:0] d, input logic [17:0] lo,
                             input logic [17:0] hi, input logic [31:0] rexp);
    for (int c = 0; c < NC; c++) begin
      string s;
      s = $sformatf("%s c%0d", tag, c);
      check({s, " ready"}, 32'(obs_ready[c]), 32'(c == NC - 1));
      if (c >= 1 && c <= 2 * W) begin
        check({s, " addr"}, 32'(obs_addr[c]), 32'((c <= W) ? lo : hi));
        check({s, " we_n"}, 32'(obs_we[c]), 32'(!wop));
        check({s, " oe"}, 32'(obs_oe[c]), 32'(wop));
        if (wop)
          check({s, " dq"}, 32'(obs_dq[c]),
                32'((c <= W) ? d[15:0] : d[31:16]));
      end else begin
        check({s, " we_n"}, 32'(obs_we[c]), 32'd1);
        check({s, " oe"}, 32'(obs_oe[c]), 32'd0);
      end
    end
    check({tag, " read_data"}, obs_rdata, rexp);
  endtask

  initial begin
    bit [31:0]   ref_w [8];
    logic [31:0] exp_rd;
    int          n;

    tbl[0] = '{1'b0, 1'b1, 32'h408,   32'hDEADBEEF, 18'h004,   18'h005,   32'h0};
    tbl[1] = '{1'b1, 1'b0, 32'h408,   32'h0,        18'h004,   18'h005,   32'hDEADBEEF};
    tbl[2] = '{1'b1, 1'b1, 32'h400,   32'h0000FFFF, 18'h000,   18'h001,   32'hDEADBEEF};
    tbl[3] = '{1'b1, 1'b0, 32'h400,   32'h0,        18'h000,   18'h001,   32'h0000FFFF};
    tbl[4] = '{1'b0, 1'b1, 32'h803FC, 32'hCAFEF00D, 18'h3FFFE, 18'h3FFFF, 32'h0000FFFF};
    tbl[5] = '{1'b1, 1'b0, 32'h80400, 32'h0,        18'h000,   18'h001,   32'h0000FFFF};
    tbl[6] = '{1'b1, 1'b0, 32'h803FF, 32'h0,        18'h3FFFE, 18'h3FFFF, 32'hCAFEF00D};
    tbl[7] = '{1'b1, 1'b0, 32'h3FC,   32'h0,        18'h3FFFE, 18'h3FFFF, 32'hCAFEF00D};
    tbl[8] = '{1'b0, 1'b1, 32'h40B,   32'h11112222, 18'h004,   18'h005,   32'hCAFEF00D};
    tbl[9] = '{1'b1, 1'b0, 32'h408,   32'h0,        18'h004,   18'h005,   32'h11112222};

    repeat (3) @(posedge clk);
    #1;
    check("rst ready", 32'(ready), 32'd1);
    check("rst we_n", 32'(sram_we_n), 32'd1);
    check("rst oe", 32'(sram_dq_oe), 32'd0);
    check("rst read_data", read_data, 32'd0);
    check("rst addr", 32'(sram_addr), 32'd0);
    check("rst dq", 32'(sram_dq_out), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle ready", 32'(ready), 32'd1);
    check("idle we_n", 32'(sram_we_n), 32'd1);
    check("idle read_data", read_data, 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      run_access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, 1'b0);
      check_trace($sformatf("vec%0d", i), tbl[i].wr, tbl[i].wdata,
                  tbl[i].lo, tbl[i].hi, tbl[i].rdata);
    end

    preload(18'h004, 16'h1234);
    preload(18'h005, 16'hABCD);
    run_access(1'b1, 1'b0, 32'h408, 32'h0, 1'b0);
    check_trace("load", 1'b0, 32'h0, 18'h004, 18'h005, 32'hABCD1234);
    repeat (3) @(posedge clk);
    #1;
    check("load held", read_data, 32'hABCD1234);

    run_access(1'b1, 1'b0, 32'h408, 32'h0, 1'b1);
    check_trace("hold", 1'b0, 32'h0, 18'h004, 18'h005, 32'hABCD1234);
    @(negedge clk);
    check("hold c6 ready", 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (ready) break;
      n++;
      @(posedge clk);
      #1;
    end
    check("hold second stall", 32'(n), 32'(2 * W));
    check("hold second data", read_data, 32'hABCD1234);
    @(posedge clk);
    #1;

    wr_en      = 1'b1;
    address    = 32'h410;
    write_data = 32'h55556666;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("mid we_n before", 32'(sram_we_n), 32'd0);
    check("mid addr before", 32'(sram_addr), 32'h009);
    #2;
    rst = 1'b0;
    #1;
    check("mid rst we_n", 32'(sram_we_n), 32'd1);
    check("mid rst oe", 32'(sram_dq_oe), 32'd0);
    check("mid rst ready", 32'(ready), 32'd0);
    check("mid rst read_data", read_data, 32'd0);
    wr_en = 1'b0;
    #1;
    check("mid rst ready idle", 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("post rst ready", 32'(ready), 32'd1);
    check("post rst we_n", 32'(sram_we_n), 32'd1);
    @(posedge clk);
    #1;
    run_access(1'b1, 1'b0, 32'h408, 32'h0, 1'b0);
    check_trace("post rst load", 1'b0, 32'h0, 18'h004, 18'h005,
                32'hABCD1234);

    exp_rd = 32'hABCD1234;
    for (int i = 0; i < 8; i++) begin
      ref_w[i] = $urandom;
      preload(18'(64 + 2 * i), ref_w[i][15:0]);
      preload(18'(65 + 2 * i), ref_w[i][31:16]);
    end
    for (int t = 0; t < 40; t++) begin
      int unsigned k;
      int unsigned op;
      logic [31:0] a;
      logic [31:0] d;
      logic        r;
      logic        w;
      k  = $urandom_range(0, 7);
      op = $urandom_range(0, 2);
      a  = BASE + 32'((32 + k) * 4) + 32'($urandom_range(0, 3))
         + 32'h80000 * 32'($urandom_range(0, 3));
      d  = $urandom;
      r  = (op != 1);
      w  = (op != 0);
      if (w) ref_w[k] = d;
      else exp_rd = ref_w[k];
      run_access(r, w, a, d, 1'b0);
      check_trace($sformatf("rnd%0d", t), w, d, 18'(64 + 2 * k),
                  18'(65 + 2 * k), exp_rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_sram_ctrl.md
# mem_sram_ctrl

Memory-stage controller between the EXE/MEM pipeline register and a 16-bit external SRAM. It takes the ALU result (byte address) and the forwarded Rm value (store data) produced by the execute stage. Each 32-bit load or store becomes two 16-bit SRAM accesses, each with a programmable wait. While an access is in flight, `ready` drops so the hazard/freeze logic can stall the pipeline.

## Interface
- `WAIT_CYCLES`, default 2: cycles each 16-bit half is held on the SRAM bus; legal range 1..15.
- `BASE_ADDR`, default 1024: byte address mapped to SRAM word 0.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `rd_en`  in  1  load request (MEM_R_en from EXE/MEM register).
- `wr_en`  in  1  store request (MEM_W_EN from EXE/MEM register).
- `address`  in  32  byte address (ALU result).
- `write_data`  in  32  store data (Val_Rm).
- `read_data`  out  32  load result.
- `ready`  out  1  high when no access is pending; pipeline freeze = ~ready.
- `sram_addr`  out  18  SRAM halfword address.
- `sram_dq_out`  out  16  write data to SRAM.
- `sram_dq_in`  in  16  read data from SRAM.
- `sram_dq_oe`  out  1  drive enable for the DQ pad.
- `sram_we_n`  out  1  SRAM write strobe, active-low.

## Operation
- States: IDLE, LOW, HIGH, DONE. A wait counter (4 bit) counts 0..WAIT_CYCLES-1 inside LOW and HIGH.
- IDLE:
  - `ready` = ~(rd_en | wr_en), combinational.
  - On a request, latch the operation, `address` and `write_data`; next state is LOW.
- Operation select: if both `rd_en` and `wr_en` are high, the access is a write.
- Address mapping: off = latched address − BASE_ADDR (32-bit wrap); word = off[18:2].
  - LOW phase: `sram_addr` = {word, 1'b0}.
  - HIGH phase: `sram_addr` = {word, 1'b1}.
  - off[1:0] is ignored.
- LOW state:
  - Drive the low half: write data [15:0]; `sram_dq_oe` and `sram_we_n`=0 for a write.
  - After WAIT_CYCLES cycles, go to HIGH.
  - For a read, capture `sram_dq_in` into read_data[15:0] on the last LOW cycle.
- HIGH state: same as LOW for bits [31:16]. After WAIT_CYCLES cycles, go to DONE.
- DONE state:
  - `ready`=1 for exactly one cycle, with `sram_we_n`=1 and `sram_dq_oe`=0.
  - Next state is always IDLE, even if requests are still high. The pipeline advances on this edge.
  - This prevents re-triggering on the same instruction.
- `read_data` holds its value until the next read overwrites it; writes never change `read_data`.
- Inputs are sampled only in IDLE. Changes to inputs during LOW, HIGH or DONE are ignored.

## Timing
- Reset (async, `rst`=0) values:
  - State IDLE, counter 0, `read_data`=0.
  - `sram_addr`=0, `sram_dq_out`=0, `sram_dq_oe`=0, `sram_we_n`=1.
  - `ready` = ~(rd_en|wr_en). This is 1 with requests low.
- A request first seen at cycle 0 (IDLE, `ready`=0) gives:
  - LOW: cycles 1..W.
  - HIGH: cycles W+1..2W.
  - DONE: cycle 2W+1, `ready`=1.
  - IDLE again: cycle 2W+2.
- Stall length is therefore 2W+1 cycles; with W=2, `ready` is high in cycle 5.
- `sram_we_n` is low on every cycle of LOW/HIGH for a write. Address and data are stable for the whole phase; they are registered outputs that change only on phase entry.
- A new request present in IDLE at cycle 2W+2 starts a new access immediately, so back-to-back accesses have no bubble beyond DONE.
- Reset asserted mid-access aborts the access at once:
  - `sram_we_n` returns to 1 asynchronously.
  - A partial halfword write is allowed to corrupt memory.
  - `read_data` clears to 0.
- `address` = BASE_ADDR+0x7FFFC maps to word 0x1FFFF. Higher offsets wrap modulo 2^17 words.

## Test plan
- Reset, then idle:
  - Stimulus: hold `rst`=0 for 3 cycles, release, keep rd_en=wr_en=0.
  - Response: `ready`=1, `sram_we_n`=1, `sram_dq_oe`=0, `read_data`=0.
- Store, W=2:
  - Stimulus: wr_en, `address`=0x408, `write_data`=0xDEADBEEF.
  - Response: cycles 1–2 have `sram_addr`=0x004, dq_out=0xBEEF, we_n=0. Cycles 3–4 have `sram_addr`=0x005, dq_out=0xDEAD, we_n=0. `ready`=1 only in cycle 5.
- Load:
  - Stimulus: SRAM model holds 0x1234 at 0x004 and 0xABCD at 0x005; rd_en, `address`=0x408.
  - Response: `read_data`=0xABCD1234 in cycle 5, held afterwards; we_n stays 1; dq_oe stays 0.
- Requests held high through DONE:
  - Stimulus: keep rd_en high through DONE.
  - Response: exactly one access is performed, then a second one starts at cycle 6 (IDLE). Check `ready` is low in 0–4, high in 5, low again in 6.
- Simultaneous rd_en and wr_en:
  - Stimulus: rd_en=wr_en=1, `address`=0x400, `write_data`=0x0000FFFF.
  - Response: a write to 0x000/0x001 is performed; `read_data` is unchanged.
- Reset mid-access:
  - Stimulus: assert `rst` in cycle 3 of a store.
  - Response: `sram_we_n`=1 and `ready` returns to ~(rd_en|wr_en) immediately (0 while a request is held); state IDLE after release; the next load completes normally.
